// File: rtl/nprime0_pkg.sv
// Shared constants for the Montgomery precompute path: word width and the
// nprime0 solver state encoding decoded by the core and its benches.
package nprime0_pkg;

  localparam int unsigned DataWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/nprime0_calc.sv
// Bit-serial solver for nprime0 = -n0^-1 mod 2^DATA_WIDTH, one result bit per clock.
// Even n0 has no inverse: err_even is raised and nprime0 is forced to zero.
module nprime0_calc
  import nprime0_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] n0_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err_even,
  output logic [DATA_WIDTH-1:0] nprime0,
  output logic [1:0]            state
);

  localparam int unsigned KW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [KW-1:0] KLast = KW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] n0_q, n0_d;
  logic [DATA_WIDTH:0]   t_q, t_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]         k_q, k_d;
  logic [DATA_WIDTH-1:0] nprime0_q, nprime0_d;
  logic                  err_even_q, err_even_d;
  logic [DATA_WIDTH:0]   sum;

  // One extra bit keeps the carry of t + n0 before the halving shift.
  assign sum = t_q + (t_q[0] ? {1'b0, n0_q} : '0);

  always_comb begin
    state_d    = state_q;
    n0_d       = n0_q;
    t_d        = t_q;
    y_d        = y_q;
    k_d        = k_q;
    nprime0_d  = nprime0_q;
    err_even_d = err_even_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (n0_in[0]) begin
            n0_d       = n0_in;
            t_d        = {{DATA_WIDTH{1'b0}}, 1'b1};
            y_d        = '0;
            k_d        = '0;
            err_even_d = 1'b0;
            state_d    = StIter;
          end else begin
            err_even_d = 1'b1;
            nprime0_d  = '0;
            state_d    = StDone;
          end
        end
      end
      StIter: begin
        y_d[k_q] = t_q[0];
        t_d      = sum >> 1;
        if (k_q == KLast) begin
          nprime0_d = y_d;
          state_d   = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      n0_q       <= '0;
      t_q        <= '0;
      y_q        <= '0;
      k_q        <= '0;
      nprime0_q  <= '0;
      err_even_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n0_q       <= n0_d;
      t_q        <= t_d;
      y_q        <= y_d;
      k_q        <= k_d;
      nprime0_q  <= nprime0_d;
      err_even_q <= err_even_d;
    end
  end

  assign busy     = (state_q == StIter);
  assign done     = (state_q == StDone);
  assign err_even = err_even_q;
  assign nprime0  = nprime0_q;
  assign state    = state_q;

endmodule
